// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer_if
//  Description : Bundles the lock/soft-reset inputs and the sequenced reset
//                outputs of reset_sequencer. The slave modport is the
//                sequencer's view; the master modport is the driving side.
//                RESET_SEQ_LOSS_COUNT_EN adds the o_loss_count signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
  parameter int CHANNELS = 4
);

  logic                i_locked;
  logic                i_soft_reset;
  logic [CHANNELS-1:0] o_channel_reset;
  logic                o_running;
  logic [1:0]          o_state;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [7:0]          o_loss_count;
`endif

`ifdef RESET_SEQ_LOSS_COUNT_EN
  modport slave (
    input  i_locked,
    input  i_soft_reset,
    output o_channel_reset,
    output o_running,
    output o_state,
    output o_loss_count
  );

  modport master (
    output i_locked,
    output i_soft_reset,
    input  o_channel_reset,
    input  o_running,
    input  o_state,
    input  o_loss_count
  );
`else
  modport slave (
    input  i_locked,
    input  i_soft_reset,
    output o_channel_reset,
    output o_running,
    output o_state
  );

  modport master (
    output i_locked,
    output i_soft_reset,
    input  o_channel_reset,
    input  o_running,
    input  o_state
  );
`endif

endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Holds CHANNELS reset domains in reset until the synchronised
//                PLL lock has been stable for HOLD_CYCLES, then releases them
//                in ascending order every STAGE_GAP cycles. Lock loss or a
//                soft-reset request re-arms the whole sequence.
//                Optional macro RESET_SEQ_LOSS_COUNT_EN adds a saturating
//                8-bit count of lock-loss events (o_loss_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 63,
  parameter int STAGE_GAP   = 16
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.slave   bus
);

  // Counter widths leave room for the terminal value itself.
  localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);
  localparam int c_gap_w  = $clog2(STAGE_GAP + 1);
  localparam int c_idx_w  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(HOLD_CYCLES);
  // The gap counter restarts at 0 on a release, so the next release happens
  // on the edge where it would have reached STAGE_GAP.
  localparam logic [c_gap_w-1:0]  c_gap_last = c_gap_w'(STAGE_GAP - 1);
  localparam logic [c_idx_w-1:0]  c_last_ch  = c_idx_w'(CHANNELS - 1);
  localparam logic [c_idx_w-1:0]  c_first_ch = c_idx_w'((CHANNELS > 1) ? 1 : 0);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic                r_lock_meta;
  logic                r_lock_s;
  state_t              r_state;
  logic [CHANNELS-1:0] r_channel_reset;
  logic                r_running;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic [c_idx_w-1:0]  r_next_ch;
  logic                w_abort;

  // Two-flop synchroniser bringing the asynchronous PLL lock into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= bus.i_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Lock loss and soft reset are one and the same abort condition.
  assign w_abort = ~r_lock_s | bus.i_soft_reset;

  // Sequencing FSM: hold, then staggered release, with abort overriding all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_WAIT_LOCK;
      r_channel_reset <= '1;
      r_running       <= 1'b0;
      r_hold_cnt      <= '0;
      r_gap_cnt       <= '0;
      r_next_ch       <= '0;
    end else if (w_abort) begin
      r_state         <= ST_WAIT_LOCK;
      r_channel_reset <= '1;
      r_running       <= 1'b0;
      r_hold_cnt      <= '0;
      r_gap_cnt       <= '0;
      r_next_ch       <= '0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          // Lock is stable and no soft reset: this edge is hold cycle 1.
          r_channel_reset <= '1;
          r_hold_cnt      <= c_hold_w'(1);
          r_state         <= ST_HOLD;
        end

        ST_HOLD: begin
          if (r_hold_cnt == c_hold_max) begin
            r_channel_reset[0] <= 1'b0;
            r_gap_cnt          <= '0;
            r_next_ch          <= c_first_ch;
            if (CHANNELS == 1) begin
              r_running <= 1'b1;
              r_state   <= ST_RUN;
            end else begin
              r_state   <= ST_RELEASE;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (r_gap_cnt == c_gap_last) begin
            r_channel_reset[r_next_ch] <= 1'b0;
            r_gap_cnt                  <= '0;
            if (r_next_ch == c_last_ch) begin
              r_running <= 1'b1;
              r_state   <= ST_RUN;
            end else begin
              r_next_ch <= r_next_ch + 1'b1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: begin
          // ST_RUN: every domain released, outputs stay put.
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.o_channel_reset = r_channel_reset;
  assign bus.o_running       = r_running;
  assign bus.o_state         = r_state;

`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic       r_lock_s_d;
  logic [7:0] r_loss_count;

  // Count falling edges of the synchronised lock, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_s_d   <= 1'b0;
      r_loss_count <= '0;
    end else begin
      r_lock_s_d <= r_lock_s;
      if (r_lock_s_d && !r_lock_s && (r_loss_count != 8'hFF)) begin
        r_loss_count <= r_loss_count + 8'd1;
      end
    end
  end

  assign bus.o_loss_count = r_loss_count;
`endif

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the fixed 63-cycle CPU reset hold at the top level.
- Holds N downstream reset domains in reset until the PLL lock is stable for a programmable time, then releases them one by one at a fixed spacing.
- Re-arms automatically on PLL lock loss or a software reset request.
- Sits between the PLL (PLLE2_BASE LOCKED output) and the clk50-domain blocks, such as the Quokka top level and its peripherals.

Parameters:
- CHANNELS, 4: number of independent reset outputs; range 1..16.
- HOLD_CYCLES, 63: cycles of continuous synchronised lock required before channel 0 releases; range 1..65535.
- STAGE_GAP, 16: cycles between releases of consecutive channels; range 1..65535.

Ports:
- Clock  in  1  system clock (clk50 domain).
- Reset  in  1  synchronous, active-high reset; overrides all other inputs.
- Locked  in  1  PLL lock; asynchronous to Clock; internally double-flop synchronised.
- SoftReset  in  1  synchronous, active-high request to re-run the sequence.
- ChannelReset  out  CHANNELS  per-channel reset, active-high, registered; bit 0 releases first.
- Running  out  1  high once all channels are released.
- State  out  2  current FSM state: 0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN.

Behaviour:
- Reset values: ChannelReset = all ones, Running = 0, State = WAIT_LOCK. Counters and both synchroniser flops clear to 0.
- Synchroniser: lock_s is the second flop output. Lock latency is 2 edges into lock_s, with outputs reacting on the following edge.
- Counter widths: internal counters are sized with $clog2 of HOLD_CYCLES and STAGE_GAP. They never wrap:
  - the hold counter stops at HOLD_CYCLES;
  - the gap counter reloads on every release.
- WAIT_LOCK:
  - all ChannelReset = 1.
  - lock_s = 1 and SoftReset = 0 -> go to HOLD with the hold counter at 1.
- HOLD:
  - the hold counter increments each cycle while lock_s = 1.
  - When it reaches HOLD_CYCLES, on that edge: ChannelReset[0] <= 0, gap counter <= 0, go to RELEASE.
  - If CHANNELS = 1, go directly to RUN and set Running <= 1 on the same edge.
- RELEASE:
  - the gap counter increments each cycle.
  - When it reaches STAGE_GAP, release the next channel k and clear the gap counter.
  - On the edge that releases channel CHANNELS-1: Running <= 1, go to RUN.
- RUN: outputs stay static.
- Abort: in any state, lock_s = 0 or SoftReset = 1 -> on that edge:
  - ChannelReset <= all ones, Running <= 0;
  - counters cleared, go to WAIT_LOCK.
- Priorities:
  - Reset beats abort; abort beats every normal transition.
  - SoftReset held high keeps the block in WAIT_LOCK.
  - SoftReset and lock loss in the same cycle count as one abort.
- Lock glitches: a lock glitch during HOLD restarts the full HOLD_CYCLES count. Partial release is never kept.
- Timing: Locked sampled high at edge n (and held) gives:
  - ChannelReset[k] low after edge n+2+HOLD_CYCLES+k*STAGE_GAP;
  - Running high with the last channel.
- Locked sampled low at edge m -> all ChannelReset high after edge m+2.
- SoftReset sampled high at edge s -> all ChannelReset high after edge s.
- Released channels never re-assert except through an abort or Reset. Ordering is strictly ascending.

Optional Feature:
- Macro: RESET_SEQ_LOSS_COUNT_EN.
- Defined:
  - adds output port LossCount (out, 8 bits);
  - increments once per falling edge of lock_s, in any state;
  - saturates at 255; cleared only by Reset; reset value 0.
  - SoftReset does not count.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- CHANNELS=3, HOLD_CYCLES=8, STAGE_GAP=4; Reset released, Locked high from edge 5 -> ChannelReset[0] low after edge 15, [1] after 19, [2] after 23; Running=1 after 23; State=3.
- Same configuration; Locked pulses low for one cycle at edge 12 (during HOLD) -> outputs stay all ones; State=0 then 1; ChannelReset[0] finally low after edge 13+2+8 = 23.
- Running in RUN; Locked sampled low at edge 40 -> ChannelReset=3'b111, Running=0, State=0 after edge 42. Locked back at edge 50 -> full sequence with ch0 low after edge 60.
- Mid-RELEASE (ch0 released, ch1 pending), SoftReset high for 3 cycles -> all ones on the first edge, held for 3 cycles; HOLD restarts after SoftReset falls; sequence timing restarts from that edge.
- CHANNELS=1, HOLD_CYCLES=1 -> ChannelReset[0] and Running change on the same edge, 3 edges after Locked is sampled. Reset asserted in RUN -> all outputs return to reset values on the next edge.
- RESET_SEQ_LOSS_COUNT_EN defined: 260 lock drop/recover cycles -> LossCount=255 (saturated); Reset -> 0.
